// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the cpu_mem memory responder:
// controller state encoding, MMIO/readback addresses and the default fetch filler.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } memState_t;

    localparam logic [31:0] MMIO_CYCLE   = 32'h8000_0000;
    localparam logic [31:0] MMIO_LED     = 32'h8000_0004;
    localparam logic [31:0] IMEM_RB_BASE = 32'h4000_0000;
    localparam logic [31:0] NOP_DEFAULT  = 32'h0000_0033;

    function automatic logic isAligned(input logic [1:0] lowBits);
        return lowBits == 2'b00;
    endfunction

endpackage

// File: rtl/cpu_mem_loader.sv
// Boot/run/fault controller: streams the program into imem while the CPU is held
// in reset, then releases it and latches a sticky fault on misaligned accesses.
module cpu_mem_loader
    import cpu_mem_pkg::*;
#(
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load_valid,
    input  logic             load_last,
    output logic             load_ready,
    input  logic             fetchAligned,
    input  logic             we,
    input  logic             dataAligned,
    output logic [1:0]       stateOut,
    output logic [PTR_W-1:0] loadPtr,
    output logic             loadWe,
    output logic             storeOk,
    output logic             cpu_n_reset,
    output logic             fault
);

    memState_t        stateReg, stateNext;
    logic [PTR_W-1:0] loadPtrReg, loadPtrNext;
    logic             readyReg, cpuRunReg, faultReg;

    // The handshake/status outputs are registered copies of the next state so
    // they change on the very edge that moves the controller.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            stateReg   <= LOAD;
            loadPtrReg <= '0;
            readyReg   <= 1'b1;
            cpuRunReg  <= 1'b0;
            faultReg   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            loadPtrReg <= loadPtrNext;
            readyReg   <= (stateNext == LOAD);
            cpuRunReg  <= (stateNext == RUN);
            faultReg   <= (stateNext == FAULT);
        end
    end

    always_comb begin
        stateNext   = stateReg;
        loadPtrNext = loadPtrReg;
        loadWe      = 1'b0;
        storeOk     = 1'b0;
        case (stateReg)
            LOAD: begin
                if (load_valid && readyReg) begin
                    loadWe      = 1'b1;
                    loadPtrNext = loadPtrReg + 1'b1;
                    if (load_last || (loadPtrReg == '1)) begin
                        stateNext = RUN;
                    end
                end
            end
            RUN: begin
                // A faulting cycle commits nothing, including an otherwise aligned store.
                if (!fetchAligned || (we && !dataAligned)) begin
                    stateNext = FAULT;
                end else begin
                    storeOk = we;
                end
            end
            FAULT: begin
                stateNext = FAULT;
            end
            default: begin
                stateNext = LOAD;
            end
        endcase
    end

    assign stateOut    = stateReg;
    assign loadPtr     = loadPtrReg;
    assign load_ready  = readyReg;
    assign cpu_n_reset = cpuRunReg;
    assign fault       = faultReg;

endmodule

// File: rtl/cpu_mem.sv
// Memory-side responder for the single-cycle CPU: combinational fetch/load, clocked
// stores, MMIO cycle counter and LED. Define CPU_MEM_READBACK_EN to map imem for reads.
module cpu_mem
    import cpu_mem_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] NOP_WORD   = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_n_reset,
    input  logic [31:0] instrAddr,
    output logic [31:0] instr,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic [7:0]  led,
    output logic        fault
);

    localparam int IK = $clog2(IMEM_WORDS);
    localparam int DK = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    logic [1:0]    stateBits;
    memState_t     state;
    logic [IK-1:0] loadPtr;
    logic          loadWe;
    logic          storeOk;
    logic [31:0]   cycleReg;
    logic [7:0]    ledReg;
    logic          fetchHit, dmemHit, cycleHit, ledHit;

    cpu_mem_loader #(
        .PTR_W(IK)
    ) u_loader (
        .clk         (clk),
        .n_reset     (n_reset),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .fetchAligned(isAligned(instrAddr[1:0])),
        .we          (we),
        .dataAligned (isAligned(dataAddr[1:0])),
        .stateOut    (stateBits),
        .loadPtr     (loadPtr),
        .loadWe      (loadWe),
        .storeOk     (storeOk),
        .cpu_n_reset (cpu_n_reset),
        .fault       (fault)
    );

    assign state = memState_t'(stateBits);

    // Memory arrays carry no reset so contents survive an n_reset pulse.
    always_ff @(posedge clk) begin
        if (loadWe) begin
            imem[loadPtr] <= load_data;
        end
        if (storeOk && dmemHit) begin
            dmem[dataAddr[DK+1:2]] <= writeData;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cycleReg <= '0;
            ledReg   <= '0;
        end else begin
            if (state == LOAD) begin
                cycleReg <= '0;
            end else if (state == RUN) begin
                cycleReg <= cycleReg + 32'd1;
            end
            if (storeOk && ledHit) begin
                ledReg <= writeData[7:0];
            end
        end
    end

    assign fetchHit = (instrAddr[31:IK+2] == '0);
    assign instr    = fetchHit ? imem[instrAddr[IK+1:2]] : NOP_WORD;

    assign dmemHit  = (dataAddr[31:DK+2] == '0);
    assign cycleHit = (dataAddr == MMIO_CYCLE);
    assign ledHit   = (dataAddr == MMIO_LED);

`ifdef CPU_MEM_READBACK_EN
    logic rbHit;
    assign rbHit = (dataAddr[31:IK+2] == IMEM_RB_BASE[31:IK+2]);
`endif

    always_comb begin
        readData = '0;
        if (dmemHit) begin
            readData = dmem[dataAddr[DK+1:2]];
        end else if (cycleHit) begin
            readData = cycleReg;
        end else if (ledHit) begin
            readData = {24'b0, ledReg};
        end
`ifdef CPU_MEM_READBACK_EN
        else if (rbHit) begin
            readData = imem[dataAddr[IK+1:2]];
        end
`endif
    end

    assign led = ledReg;

endmodule

// File: tb/tb_cpu_mem.sv
// Scoreboard bench for cpu_mem: stimulus queues expected values, a negedge monitor
// pops and compares them against the selected DUT output.
module tb_cpu_mem;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        cpu_n_reset;
    logic [31:0] instrAddr = '0;
    logic [31:0] instr;
    logic [31:0] dataAddr = '0;
    logic [31:0] writeData = '0;
    logic        we = 1'b0;
    logic [31:0] readData;
    logic [7:0]  led;
    logic        fault;

    localparam int SEL_INSTR = 0, SEL_RDATA = 1, SEL_LED = 2, SEL_FAULT = 3, SEL_CPURST = 4, SEL_READY = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   modelCycle = 0;
    bit   modelRun = 1'b0;

    cpu_mem dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_n_reset(cpu_n_reset),
        .instrAddr  (instrAddr),
        .instr      (instr),
        .dataAddr   (dataAddr),
        .writeData  (writeData),
        .we         (we),
        .readData   (readData),
        .led        (led),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dutSig(input int sel);
        case (sel)
            SEL_INSTR:  return instr;
            SEL_RDATA:  return readData;
            SEL_LED:    return {24'b0, led};
            SEL_FAULT:  return {31'b0, fault};
            SEL_CPURST: return {31'b0, cpu_n_reset};
            default:    return {31'b0, load_ready};
        endcase
    endfunction

    // Monitor: compares every queued expectation at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                chk_t        c;
                logic [31:0] act;
                c   = sb.pop_front();
                act = dutSig(c.sel);
                testsRun++;
                if (act !== c.exp) begin
                    testsFailed++;
                    $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", c.name, act, c.exp);
                end else begin
                    $display("[TB] ok   %s: 0x%08h", c.name, act);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic pushExp(input string n, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = n;
        c.sel  = sel;
        c.exp  = v;
        sb.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        if (modelRun) modelCycle++;
        #1;
    endtask

    task automatic loadWord(input logic [31:0] d, input logic l);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = l;
        pushExp("load_ready_while_loading", SEL_READY, 32'd1);
        pushExp("cpu_held_while_loading", SEL_CPURST, 32'd0);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #1;
        pushExp("rst_load_ready", SEL_READY, 32'd1);
        pushExp("rst_cpu_n_reset", SEL_CPURST, 32'd0);
        pushExp("rst_led", SEL_LED, 32'd0);
        pushExp("rst_fault", SEL_FAULT, 32'd0);
        tick();
        tick();
        n_reset = 1'b1;
        tick();

        // Two of five words, then a reset pulse mid-load.
        loadWord(32'hDEAD_0001, 1'b0);
        loadWord(32'hDEAD_0002, 1'b0);
        n_reset = 1'b0;
        pushExp("midload_rst_ready", SEL_READY, 32'd1);
        pushExp("midload_rst_cpu", SEL_CPURST, 32'd0);
        tick();
        n_reset = 1'b1;
        tick();

        // Stores during LOAD must be ignored.
        we = 1'b1; dataAddr = 32'h8000_0004; writeData = 32'h0000_00FF;
        loadWord(32'h0000_0033, 1'b0);
        loadWord(32'h0F00_0093, 1'b0);
        loadWord(32'h00F0_8093, 1'b1);
        we = 1'b0;
        modelRun = 1'b1;
        modelCycle = 0;

        instrAddr = 32'h0; dataAddr = 32'h8000_0000;
        pushExp("run_load_ready", SEL_READY, 32'd0);
        pushExp("run_cpu_n_reset", SEL_CPURST, 32'd1);
        pushExp("led_untouched_by_load_store", SEL_LED, 32'd0);
        pushExp("instr0_overwritten", SEL_INSTR, 32'h0000_0033);
        pushExp("cycle_first", SEL_RDATA, modelCycle);
        tick();
        instrAddr = 32'h4;
        pushExp("instr_at_4", SEL_INSTR, 32'h0F00_0093);
        pushExp("cycle_next", SEL_RDATA, modelCycle);
        tick();
        instrAddr = 32'h8;
        we = 1'b1; dataAddr = 32'h10; writeData = 32'h0000_1111;
        pushExp("instr_at_8", SEL_INSTR, 32'h00F0_8093);
        tick();
        instrAddr = 32'h400;
        writeData = 32'h0000_01FE;
        pushExp("fetch_oob_nop", SEL_INSTR, 32'h0000_0033);
        pushExp("read_during_write_old", SEL_RDATA, 32'h0000_1111);
        tick();
        instrAddr = 32'hFFFF_FFFC;
        we = 1'b0;
        pushExp("store_then_load", SEL_RDATA, 32'h0000_01FE);
        pushExp("fetch_high_nop", SEL_INSTR, 32'h0000_0033);
        tick();
        instrAddr = 32'h0;
        we = 1'b1; dataAddr = 32'h8000_0004; writeData = 32'h0000_01A5;
        tick();
        we = 1'b0;
        pushExp("led_write", SEL_LED, 32'h0000_00A5);
        pushExp("led_read", SEL_RDATA, 32'h0000_00A5);
        tick();
        we = 1'b1; dataAddr = 32'h0; writeData = 32'h0000_0077;
        tick();
        dataAddr = 32'h400; writeData = 32'h0000_0055;
        tick();
        we = 1'b0; dataAddr = 32'h0;
        pushExp("dmem0_not_aliased", SEL_RDATA, 32'h0000_0077);
        tick();
        dataAddr = 32'h400;
        pushExp("unmapped_reads_zero", SEL_RDATA, 32'h0);
        tick();
        we = 1'b1; dataAddr = 32'h8000_0000; writeData = 32'h0;
        pushExp("cycle_during_write", SEL_RDATA, modelCycle);
        tick();
        we = 1'b0;
        pushExp("cycle_read_only", SEL_RDATA, modelCycle);
        tick();
        dataAddr = 32'h4000_0004;
`ifdef CPU_MEM_READBACK_EN
        pushExp("imem_readback", SEL_RDATA, 32'h0F00_0093);
`else
        pushExp("readback_unmapped", SEL_RDATA, 32'h0);
`endif
        tick();
        we = 1'b1; dataAddr = 32'h3FC; writeData = 32'h0000_CAFE;
        tick();
        we = 1'b0;
        pushExp("dmem_top_word", SEL_RDATA, 32'h0000_CAFE);
        tick();
        dataAddr = 32'h13;
        tick();
        pushExp("misaligned_read_no_fault", SEL_FAULT, 32'd0);
        pushExp("misaligned_read_cpu_runs", SEL_CPURST, 32'd1);
        we = 1'b1; dataAddr = 32'h2; writeData = 32'h0000_0BAD;
        tick();
        modelRun = 1'b0;
        we = 1'b0; dataAddr = 32'h0;
        pushExp("fault_set", SEL_FAULT, 32'd1);
        pushExp("fault_cpu_reset", SEL_CPURST, 32'd0);
        pushExp("fault_load_ready", SEL_READY, 32'd0);
        pushExp("fault_store_dropped", SEL_RDATA, 32'h0000_0077);
        tick();
        dataAddr = 32'h8000_0000;
        pushExp("fault_cycle_frozen_a", SEL_RDATA, modelCycle);
        tick();
        pushExp("fault_cycle_frozen_b", SEL_RDATA, modelCycle);
        tick();

        n_reset = 1'b0;
        pushExp("rerst_fault", SEL_FAULT, 32'd0);
        pushExp("rerst_ready", SEL_READY, 32'd1);
        pushExp("rerst_led", SEL_LED, 32'd0);
        pushExp("rerst_cycle", SEL_RDATA, 32'd0);
        tick();
        n_reset = 1'b1;
        dataAddr = 32'h10;
        pushExp("dmem_preserved", SEL_RDATA, 32'h0000_01FE);
        tick();
        tick();

        testsRun++;
        if (readData !== 32'h0000_01FE) begin
            testsFailed++;
            $display("[TB] FAIL final_dmem_preserved: got 0x%08h, expected 0x%08h", readData, 32'h0000_01FE);
        end else begin
            $display("[TB] ok   final_dmem_preserved: 0x%08h", readData);
        end
        testsRun++;
        if (load_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL final_load_ready: got %0b, expected 1", load_ready);
        end else begin
            $display("[TB] ok   final_load_ready: %0b", load_ready);
        end
        testsRun++;
        if (cpu_n_reset !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL final_cpu_held: got %0b, expected 0", cpu_n_reset);
        end else begin
            $display("[TB] ok   final_cpu_held: %0b", cpu_n_reset);
        end
        testsRun++;
        if (fault !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL final_fault_clear: got %0b, expected 0", fault);
        end else begin
            $display("[TB] ok   final_fault_clear: %0b", fault);
        end
        testsRun++;
        if (led !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL final_led_reset: got 0x%02h, expected 0x00", led);
        end else begin
            $display("[TB] ok   final_led_reset: 0x%02h", led);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
